// File: rtl/enc_pkg.sv
// Shared types, constants and cipher helpers for the encrypt engine and its matching decrypter.
// Helpers work on a MAX_W-wide container; bits at or above the live width w are returned as zero.
package enc_pkg;

  localparam int SALT_W = 16;
  localparam int MODE_W = 2;
  localparam int MAX_W  = 128;

  localparam logic [SALT_W-1:0] LFSR_TAPS    = 16'hB400;
  localparam logic [SALT_W-1:0] LFSR_DEFAULT = 16'hACE1;

  typedef enum logic [MODE_W-1:0] {
    ENC_XOR = 2'd0,
    ENC_ROT = 2'd1,
    ENC_ADD = 2'd2,
    ENC_REV = 2'd3
  } enc_mode_e;

  typedef logic [MAX_W-1:0] wide_t;

  // ks[i] = key[i] ^ salt[i mod 16] for i < w.
  function automatic wide_t ks_expand(input wide_t key, input logic [SALT_W-1:0] salt,
                                      input int w);
    wide_t ks;
    ks = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < w) begin
        ks[i[6:0]] = key[i[6:0]] ^ salt[i[3:0]];
      end
    end
    return ks;
  endfunction

  // Rotate left by r within the low w bits; caller guarantees r < w.
  function automatic wide_t rotl_mod(input wide_t p, input int r, input int w);
    wide_t o;
    int    idx;
    o = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < w) begin
        idx = i + w - r;
        if (idx >= w) begin
          idx = idx - w;
        end
        o[i[6:0]] = p[idx[6:0]];
      end
    end
    return o;
  endfunction

  function automatic wide_t bit_rev(input wide_t p, input int w);
    wide_t o;
    int    idx;
    o = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < w) begin
        idx = w - 1 - i;
        o[i[6:0]] = p[idx[6:0]];
      end
    end
    return o;
  endfunction

endpackage

// File: rtl/enc_lfsr16.sv
// 16-bit right-shifting Galois LFSR that steps only when enabled; a zero seed maps to the default.
module enc_lfsr16
  import enc_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic [SALT_W-1:0] i_seed,
  output logic [SALT_W-1:0] o_state
);

  logic [SALT_W-1:0] r_state;
  logic [SALT_W-1:0] w_seed_eff;
  logic [SALT_W-1:0] w_next;

  // The all-zero state is a fixed point, so it can never be the reset value.
  assign w_seed_eff = (i_seed == '0) ? LFSR_DEFAULT : i_seed;
  assign w_next     = r_state[0] ? ((r_state >> 1) ^ LFSR_TAPS) : (r_state >> 1);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= w_seed_eff;
    end else if (i_en) begin
      r_state <= w_next;
    end
  end

  assign o_state = r_state;

endmodule

// File: rtl/encrypt_engine_p.sv
// Two-stage valid/ready encrypter: S1 captures block, mode, salt and key; S2 holds {mode, salt, cipher}.
// The cipher is computed combinationally from S1 and registered into S2.
module encrypt_engine_p
  import enc_pkg::*;
#(
  parameter int unsigned       DATA_W    = 60,
  parameter logic [SALT_W-1:0] SEED      = 16'hACE1,
  parameter logic [DATA_W-1:0] KEY_INIT  = '0,
  parameter bit                AUTO_MODE = 1'b0
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic                              i_key_load,
  input  logic [DATA_W-1:0]                 i_key_in,
  input  logic                              i_in_valid,
  output logic                              o_in_ready,
  input  logic [DATA_W-1:0]                 i_in_data,
  input  logic [MODE_W-1:0]                 i_mode_in,
  output logic                              o_out_valid,
  input  logic                              i_out_ready,
  output logic [DATA_W+SALT_W+MODE_W-1:0]   o_out_data,
  output logic [31:0]                       o_blk_cnt
);

  localparam int unsigned OUT_W = DATA_W + SALT_W + MODE_W;
  localparam int unsigned RW    = $clog2(DATA_W);

  if (DATA_W < 16 || DATA_W > 128) begin : g_bad_width
    $error("encrypt_engine_p: DATA_W must be within 16..128");
  end

  logic              w_accept;
  logic              w_adv;
  logic [SALT_W-1:0] w_salt;
  enc_mode_e         w_mode_sel;

  logic [DATA_W-1:0] r_key;

  logic              r_s1_valid;
  logic [DATA_W-1:0] r_s1_data;
  logic [DATA_W-1:0] r_s1_key;
  enc_mode_e         r_s1_mode;
  logic [SALT_W-1:0] r_s1_salt;

  logic              r_out_valid;
  logic [OUT_W-1:0]  r_out_data;
  logic [31:0]       r_blk_cnt;

  wide_t             w_p_ext;
  wide_t             w_key_ext;
  wide_t             w_ks;
  int                w_rot;
  logic [DATA_W-1:0] w_cipher;

  assign w_adv      = !r_out_valid || i_out_ready;
  assign o_in_ready = !r_s1_valid || w_adv;
  assign w_accept   = i_in_valid && o_in_ready;
  assign w_mode_sel = AUTO_MODE ? enc_mode_e'(w_salt[SALT_W-1 -: MODE_W])
                                : enc_mode_e'(i_mode_in);

  enc_lfsr16 u_lfsr (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_en    (w_accept),
    .i_seed  (SEED),
    .o_state (w_salt)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_key <= KEY_INIT;
    end else if (i_key_load) begin
      r_key <= i_key_in;
    end
  end

  // The key snapshot reads r_key before a same-cycle key_load lands, so that block keeps the old key.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_s1_key   <= '0;
      r_s1_mode  <= ENC_XOR;
      r_s1_salt  <= '0;
    end else if (w_accept) begin
      r_s1_valid <= 1'b1;
      r_s1_data  <= i_in_data;
      r_s1_key   <= r_key;
      r_s1_mode  <= w_mode_sel;
      r_s1_salt  <= w_salt;
    end else if (w_adv) begin
      r_s1_valid <= 1'b0;
    end
  end

  always_comb begin
    w_p_ext                = '0;
    w_p_ext[DATA_W-1:0]    = r_s1_data;
    w_key_ext              = '0;
    w_key_ext[DATA_W-1:0]  = r_s1_key;
    w_ks                   = ks_expand(w_key_ext, r_s1_salt, int'(DATA_W));
    w_rot                  = int'({{(32 - RW){1'b0}}, r_s1_salt[RW-1:0]});
    if (w_rot >= int'(DATA_W)) begin
      w_rot = w_rot - int'(DATA_W);
    end
    w_cipher = '0;
    unique case (r_s1_mode)
      ENC_XOR: w_cipher = DATA_W'(w_p_ext ^ w_ks);
      ENC_ROT: w_cipher = DATA_W'(rotl_mod(w_p_ext, w_rot, int'(DATA_W)) ^ w_ks);
      ENC_ADD: w_cipher = DATA_W'(w_p_ext + w_ks);
      ENC_REV: w_cipher = DATA_W'(bit_rev(w_p_ext, int'(DATA_W)) ^ w_ks);
      default: w_cipher = DATA_W'(w_p_ext ^ w_ks);
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (w_adv) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_data <= {r_s1_mode, r_s1_salt, w_cipher};
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_blk_cnt <= '0;
    end else if (r_out_valid && i_out_ready) begin
      r_blk_cnt <= r_blk_cnt + 32'd1;
    end
  end

  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;
  assign o_blk_cnt   = r_blk_cnt;

endmodule
